// File: rtl/psg_audio_mixer.sv
// Stereo mixer for one or two PSG chips: panning, gain, optional leaky DC-blocking
// filter, and signed 16-bit output with a one-cycle valid strobe per accepted CE.
module psg_audio_mixer #(
    parameter int DCF_SHIFT  = 8,
    parameter int GAIN_SHIFT = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_ce,
    input  logic [1:0]         i_stereo,
    input  logic               i_dcf_en,
    input  logic               i_ch1_en,
    input  logic [7:0]         i_ch0_a,
    input  logic [7:0]         i_ch0_b,
    input  logic [7:0]         i_ch0_c,
    input  logic [7:0]         i_ch1_a,
    input  logic [7:0]         i_ch1_b,
    input  logic [7:0]         i_ch1_c,
    output logic signed [15:0] o_audio_l,
    output logic signed [15:0] o_audio_r,
    output logic               o_valid,
    output logic               o_busy,
    output logic               o_overrun
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SUM    = 3'd1;
    localparam logic [2:0] ST_FILT_L = 3'd2;
    localparam logic [2:0] ST_FILT_R = 3'd3;
    localparam logic [2:0] ST_OUT    = 3'd4;

    // One chip's contribution to one side; 1 = ABC, 2 = ACB, anything else is mono.
    function automatic logic [9:0] chip_term(input logic side_r, input logic [1:0] st,
                                             input logic [7:0] a, input logic [7:0] b,
                                             input logic [7:0] c);
        logic [9:0] t;
        case (st)
            2'd1:    t = side_r ? ({1'b0, c, 1'b0} + {2'b00, b}) : ({1'b0, a, 1'b0} + {2'b00, b});
            2'd2:    t = side_r ? ({1'b0, b, 1'b0} + {2'b00, c}) : ({1'b0, a, 1'b0} + {2'b00, c});
            default: t = {2'b00, a} + {2'b00, b} + {2'b00, c};
        endcase
        return t;
    endfunction

    // y' = x - xprev + y - (y >>> K), evaluated wide and clamped to 16-bit signed.
    function automatic logic signed [15:0] dc_step(input logic signed [16:0] x,
                                                   input logic signed [16:0] xp,
                                                   input logic signed [15:0] y);
        logic signed [15:0] ysh;
        logic signed [19:0] acc;
        logic signed [15:0] res;
        ysh = y >>> DCF_SHIFT;
        acc = {{3{x[16]}}, x} - {{3{xp[16]}}, xp} + {{4{y[15]}}, y} - {{4{ysh[15]}}, ysh};
        if (acc > 20'sd32767) begin
            res = 16'sh7FFF;
        end else if (acc < -20'sd32768) begin
            res = 16'sh8000;
        end else begin
            res = acc[15:0];
        end
        return res;
    endfunction

    logic [2:0]         r_state;
    logic [1:0]         r_stereo;
    logic               r_dcf_en;
    logic [7:0]         r_a0, r_b0, r_c0, r_a1, r_b1, r_c1;
    logic signed [16:0] r_x_l, r_x_r;
    logic signed [16:0] r_xp_l, r_xp_r;
    logic signed [15:0] r_y_l, r_y_r;
    logic signed [15:0] r_res_l, r_res_r;

    logic [10:0]        w_sum_l, w_sum_r;
    logic signed [15:0] w_filt_l, w_filt_r;

    assign w_sum_l  = {1'b0, chip_term(1'b0, r_stereo, r_a0, r_b0, r_c0)}
                    + {1'b0, chip_term(1'b0, r_stereo, r_a1, r_b1, r_c1)};
    assign w_sum_r  = {1'b0, chip_term(1'b1, r_stereo, r_a0, r_b0, r_c0)}
                    + {1'b0, chip_term(1'b1, r_stereo, r_a1, r_b1, r_c1)};
    assign w_filt_l = dc_step(r_x_l, r_xp_l, r_y_l);
    assign w_filt_r = dc_step(r_x_r, r_xp_r, r_y_r);

    // Sample sequencer: capture, mix, filter left, filter right, publish.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_stereo  <= 2'd0;
            r_dcf_en  <= 1'b0;
            r_a0      <= 8'd0;
            r_b0      <= 8'd0;
            r_c0      <= 8'd0;
            r_a1      <= 8'd0;
            r_b1      <= 8'd0;
            r_c1      <= 8'd0;
            r_x_l     <= 17'sd0;
            r_x_r     <= 17'sd0;
            r_xp_l    <= 17'sd0;
            r_xp_r    <= 17'sd0;
            r_y_l     <= 16'sd0;
            r_y_r     <= 16'sd0;
            r_res_l   <= 16'sd0;
            r_res_r   <= 16'sd0;
            o_audio_l <= 16'sd0;
            o_audio_r <= 16'sd0;
            o_valid   <= 1'b0;
            o_busy    <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_ce) begin
                        r_stereo <= i_stereo;
                        r_dcf_en <= i_dcf_en;
                        r_a0     <= i_ch0_a;
                        r_b0     <= i_ch0_b;
                        r_c0     <= i_ch0_c;
                        r_a1     <= i_ch1_en ? i_ch1_a : 8'd0;
                        r_b1     <= i_ch1_en ? i_ch1_b : 8'd0;
                        r_c1     <= i_ch1_en ? i_ch1_c : 8'd0;
                        o_busy   <= 1'b1;
                        r_state  <= ST_SUM;
                    end else begin
                        r_state  <= ST_IDLE;
                    end
                end
                ST_SUM: begin
                    r_x_l   <= {6'd0, w_sum_l} << GAIN_SHIFT;
                    r_x_r   <= {6'd0, w_sum_r} << GAIN_SHIFT;
                    r_state <= ST_FILT_L;
                end
                ST_FILT_L: begin
                    r_xp_l  <= r_x_l;
                    r_y_l   <= r_dcf_en ? w_filt_l : 16'sd0;
                    r_res_l <= r_dcf_en ? w_filt_l : r_x_l[15:0];
                    r_state <= ST_FILT_R;
                end
                ST_FILT_R: begin
                    r_xp_r  <= r_x_r;
                    r_y_r   <= r_dcf_en ? w_filt_r : 16'sd0;
                    r_res_r <= r_dcf_en ? w_filt_r : r_x_r[15:0];
                    r_state <= ST_OUT;
                end
                ST_OUT: begin
                    o_audio_l <= r_res_l;
                    o_audio_r <= r_res_r;
                    o_valid   <= 1'b1;
                    o_busy    <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    o_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky flag for strobes that arrive while a sample is still in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_overrun <= 1'b0;
        end else if (i_ce && (r_state != ST_IDLE)) begin
            o_overrun <= 1'b1;
        end else begin
            o_overrun <= o_overrun;
        end
    end

endmodule
